// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter in front of the single-port data RAM.
//   Master 0 is the core LSU, master 1 the DMA/debug port. Round-robin on
//   conflict, with a bounded bus lock for atomic read-modify-write sequences.
//   Optional macro RAM_ARB_PERF_EN adds a saturating conflict counter.
//
// Handshake: a master raises req with addr/data/sel/we and holds them stable
//   until gnt is seen high in the same cycle (gnt is combinational). Every
//   accepted request (read or write) gets exactly one rvalid pulse on the
//   following cycle; data_o carries the RAM word during that pulse, else 0.
//
// The FSM state is held in state_q (arb_state_t) so checkers can bind to it.
module ram_arbiter #(
   parameter int LOCK_MAX = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             m0_req_i,
   input  logic             m0_lock_i,
   input  logic [31:0]      m0_addr_i,
   input  logic [31:0]      m0_data_i,
   input  logic [3:0]       m0_sel_i,
   input  logic             m0_we_i,
   output logic             m0_gnt_o,
   output logic             m0_rvalid_o,
   output logic [31:0]      m0_data_o,
   input  logic             m1_req_i,
   input  logic             m1_lock_i,
   input  logic [31:0]      m1_addr_i,
   input  logic [31:0]      m1_data_i,
   input  logic [3:0]       m1_sel_i,
   input  logic             m1_we_i,
   output logic             m1_gnt_o,
   output logic             m1_rvalid_o,
   output logic [31:0]      m1_data_o,
   output logic [31:0]      ram_addr_o,
   output logic [31:0]      ram_data_o,
   output logic [3:0]       ram_sel_o,
   output logic             ram_we_o,
   input  logic [31:0]      ram_data_i,
   output logic [CNT_W-1:0] conflict_cnt_o
);

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_t;

   localparam int LCW = $clog2(LOCK_MAX + 1);

   arb_state_t     state_q, state_d;
   logic           last_q, last_d;       // master that received the most recent grant
   logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
   logic           gnt0, gnt1;
   logic           own, own_req, own_lock;
   logic           rvalid0_q, rvalid1_q;

   // State register, last-grant pointer and lock run length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB;
         last_q     <= 1'b1;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // Grant selection and next-state: round-robin in ARB, exclusive owner in LOCKn.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      lock_cnt_d = lock_cnt_q;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      own        = 1'b0;
      own_req    = 1'b0;
      own_lock   = 1'b0;
      case (state_q)
         ARB: begin
            if (m0_req_i && m1_req_i) begin
               // last_q=1 means master 1 went last, so master 0 wins now
               gnt0 = last_q;
               gnt1 = !last_q;
            end else begin
               gnt0 = m0_req_i;
               gnt1 = m1_req_i;
            end
            if (gnt0 || gnt1) begin
               last_d = gnt1;
               // with LOCK_MAX=1 a locked grant is already the last one allowed
               if (((gnt0 && m0_lock_i) || (gnt1 && m1_lock_i)) && (LOCK_MAX > 1)) begin
                  state_d    = gnt1 ? LOCK1 : LOCK0;
                  lock_cnt_d = LCW'(1);
               end
            end
         end
         LOCK0, LOCK1: begin
            own      = (state_q == LOCK1);
            own_req  = own ? m1_req_i  : m0_req_i;
            own_lock = own ? m1_lock_i : m0_lock_i;
            gnt0     = !own && m0_req_i;
            gnt1     = own && m1_req_i;
            if (own_req) begin
               last_d = own;
            end
            if (own_req && own_lock) begin
               if ((lock_cnt_q + LCW'(1)) == LCW'(LOCK_MAX)) begin
                  // forced release; last_d=own hands the next conflict to the other master
                  state_d    = ARB;
                  lock_cnt_d = '0;
               end else begin
                  lock_cnt_d = lock_cnt_q + LCW'(1);
               end
            end else begin
               state_d    = ARB;
               lock_cnt_d = '0;
            end
         end
         default: begin
            state_d    = ARB;
            lock_cnt_d = '0;
         end
      endcase
   end

   // Route the winner's request to the RAM; idle cycles keep we/sel low.
   always_comb begin
      ram_addr_o = m0_addr_i;
      ram_data_o = m0_data_i;
      ram_sel_o  = '0;
      ram_we_o   = 1'b0;
      if (gnt1) begin
         ram_addr_o = m1_addr_i;
         ram_data_o = m1_data_i;
         ram_sel_o  = m1_sel_i;
         ram_we_o   = m1_we_i;
      end else if (gnt0) begin
         ram_addr_o = m0_addr_i;
         ram_data_o = m0_data_i;
         ram_sel_o  = m0_sel_i;
         ram_we_o   = m0_we_i;
      end
   end

   // Response owner tag: the granted master sees rvalid one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         rvalid0_q <= gnt0;
         rvalid1_q <= gnt1;
      end
   end

   assign m0_gnt_o    = gnt0;
   assign m1_gnt_o    = gnt1;
   assign m0_rvalid_o = rvalid0_q;
   assign m1_rvalid_o = rvalid1_q;
   assign m0_data_o   = rvalid0_q ? ram_data_i : 32'h0;
   assign m1_data_o   = rvalid1_q ? ram_data_i : 32'h0;

`ifdef RAM_ARB_PERF_EN
   logic [CNT_W-1:0] cnt_q;
   logic             stall;

   assign stall = (m0_req_i && !gnt0) || (m1_req_i && !gnt1);

   // Count stalled cycles (lock stalls included), saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign conflict_cnt_o = cnt_q;
`else
   assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus randomized traffic for ram_arbiter,
//   checked against a transaction-level model of the arbitration rules and a
//   shadow copy of the RAM contents.
module tb_ram_arbiter;

   localparam int LOCK_MAX = 16;
   localparam int CNT_W    = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             m0_req = 1'b0, m0_lock = 1'b0, m0_we = 1'b0;
   logic [31:0]      m0_addr = '0, m0_data = '0;
   logic [3:0]       m0_sel = '0;
   logic             m1_req = 1'b0, m1_lock = 1'b0, m1_we = 1'b0;
   logic [31:0]      m1_addr = '0, m1_data = '0;
   logic [3:0]       m1_sel = '0;
   logic             m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0]      m0_rdata, m1_rdata;
   logic [31:0]      ram_addr, ram_wdata;
   logic [31:0]      ram_rdata = '0;
   logic [3:0]       ram_sel;
   logic             ram_we;
   logic [CNT_W-1:0] conflict_cnt;

   int vectors = 0;
   int miscompares = 0;

   ram_arbiter #(.LOCK_MAX(LOCK_MAX), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req_i(m0_req), .m0_lock_i(m0_lock), .m0_addr_i(m0_addr), .m0_data_i(m0_data),
      .m0_sel_i(m0_sel), .m0_we_i(m0_we), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
      .m0_data_o(m0_rdata),
      .m1_req_i(m1_req), .m1_lock_i(m1_lock), .m1_addr_i(m1_addr), .m1_data_i(m1_data),
      .m1_sel_i(m1_sel), .m1_we_i(m1_we), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
      .m1_data_o(m1_rdata),
      .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_sel_o(ram_sel), .ram_we_o(ram_we),
      .ram_data_i(ram_rdata), .conflict_cnt_o(conflict_cnt)
   );

   // clock
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
   endfunction

   // RAM: 256 words, one-cycle synchronous read, byte-enabled write, reloaded in reset
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
         ram_rdata <= '0;
      end else begin
         if (ram_we)
            for (int b = 0; b < 4; b++)
               if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
         ram_rdata <= mem[ram_addr[9:2]];
      end
   end

   // reference model state
   logic [31:0]      shadow [256];
   int               owner;        // -1: bus free, else master holding the lock
   int               run;          // grants taken in the current locked run
   int               last;         // master granted most recently
   logic [CNT_W-1:0] exp_cnt;
   logic [1:0]       exp_rv, exp_rd_chk;
   logic [31:0]      exp_rd [2];
   logic             stall0, stall1;
   logic             obs_g0, obs_g1;

   task automatic model_reset();
      owner = -1; run = 0; last = 1; exp_cnt = '0;
      exp_rv = '0; exp_rd_chk = '0; exp_rd[0] = '0; exp_rd[1] = '0;
      stall0 = 1'b0; stall1 = 1'b0;
      for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
   endtask

   function automatic int model_grant();
      if (owner == 0) return m0_req ? 0 : -1;
      if (owner == 1) return m1_req ? 1 : -1;
      if (m0_req && m1_req) return 1 - last;
      if (m0_req) return 0;
      if (m1_req) return 1;
      return -1;
   endfunction

   task automatic model_update(input int g);
      logic [31:0] a, d;
      logic [3:0]  s;
      logic        w, lk;
      stall0 = m0_req && (g != 0);
      stall1 = m1_req && (g != 1);
`ifdef RAM_ARB_PERF_EN
      if ((stall0 || stall1) && (exp_cnt != {CNT_W{1'b1}})) exp_cnt = exp_cnt + 1;
`endif
      exp_rv = '0;
      exp_rd_chk = '0;
      if (g >= 0) begin
         a  = (g == 1) ? m1_addr : m0_addr;
         d  = (g == 1) ? m1_data : m0_data;
         s  = (g == 1) ? m1_sel  : m0_sel;
         w  = (g == 1) ? m1_we   : m0_we;
         lk = (g == 1) ? m1_lock : m0_lock;
         exp_rv[g]     = 1'b1;
         exp_rd_chk[g] = !w;
         exp_rd[g]     = shadow[a[9:2]];
         if (w)
            for (int b = 0; b < 4; b++)
               if (s[b]) shadow[a[9:2]][8*b +: 8] = d[8*b +: 8];
         last = g;
         if (lk) begin
            run   = (owner == g) ? run + 1 : 1;
            owner = (run >= LOCK_MAX) ? -1 : g;
         end else begin
            owner = -1;
         end
      end else begin
         owner = -1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver: set one master's request fields
   task automatic drive(input int m, input logic req, input logic lock, input logic we,
                        input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
      if (m == 0) begin
         m0_req = req; m0_lock = lock; m0_we = we; m0_addr = addr; m0_data = data; m0_sel = sel;
      end else begin
         m1_req = req; m1_lock = lock; m1_we = we; m1_addr = addr; m1_data = data; m1_sel = sel;
      end
   endtask

   task automatic drive_rand(input int m);
      drive(m, ($urandom_range(0, 99) < 60), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
            $urandom, 4'($urandom_range(0, 15)));
   endtask

   // one cycle: inputs were set after the falling edge; check, then advance the model
   task automatic step();
      int g;
      #1;
      chk("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv[0]));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv[1]));
      if (!exp_rv[0])         chk("m0_data_idle", m0_rdata, 32'h0);
      else if (exp_rd_chk[0]) chk("m0_data", m0_rdata, exp_rd[0]);
      if (!exp_rv[1])         chk("m1_data_idle", m1_rdata, 32'h0);
      else if (exp_rd_chk[1]) chk("m1_data", m1_rdata, exp_rd[1]);
      g = model_grant();
      chk("m0_gnt", 32'(m0_gnt), 32'(g == 0));
      chk("m1_gnt", 32'(m1_gnt), 32'(g == 1));
      chk("ram_we", 32'(ram_we), 32'((g == 0 && m0_we) || (g == 1 && m1_we)));
      chk("ram_sel", 32'(ram_sel), (g == 0) ? 32'(m0_sel) : (g == 1) ? 32'(m1_sel) : 32'h0);
      chk("ram_addr", ram_addr, (g == 1) ? m1_addr : m0_addr);
      if (g >= 0) chk("ram_data", ram_wdata, (g == 1) ? m1_data : m0_data);
      chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));
      obs_g0 = m0_gnt;
      obs_g1 = m1_gnt;
      @(posedge clk);
      model_update(g);
      @(negedge clk);
   endtask

   task automatic idle_both();
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   initial begin
      int run1, stalls;
      logic [3:0] seq;
      // reset
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();                                       // reset state: no rvalid, counter 0

      // single m0 read of 0x10: grant same cycle, word next cycle
      drive(0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
      step();
      chk("t1_gnt", 32'(obs_g0), 32'h1);
      idle_both();
      #1;
      chk("t1_rdata", m0_rdata, init_word(4));
      step();

      // make master 1 the last winner, then four cycles of conflict
      drive(1, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
      step();
      drive(0, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF);
      drive(1, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0, 4'hF);
      seq = '0;
      for (int c = 0; c < 4; c++) begin
         step();
         seq = {seq[2:0], obs_g1};
      end
      chk("t2_grant_order", 32'(seq), 32'h5);
      idle_both();
      step();

      // m1 locks three grants then releases; m0 requests throughout
      drive(0, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0, 4'hF);
      step();                                       // m0 alone: m1 wins next conflict
      drive(1, 1'b1, 1'b1, 1'b1, 32'h0000_000C, 32'h1234_5678, 4'h3);
      stalls = 0;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) m1_lock = 1'b0;
         step();
         if (!obs_g0) stalls++;
      end
      chk("t3_m0_stalls", 32'(stalls), 32'd4);
      step();
      chk("t3_m0_after", 32'(obs_g0), 32'h1);
      idle_both();
      step();

      // m1 holds lock: exactly LOCK_MAX grants, then m0
      drive(0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
      step();
      drive(1, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
      run1 = 0;
      for (int c = 0; c < LOCK_MAX; c++) begin
         step();
         if (obs_g1) run1++;
      end
      chk("t4_m1_run", 32'(run1), 32'(LOCK_MAX));
      step();
      chk("t4_m0_next", 32'(obs_g0), 32'h1);
      idle_both();
      step();

      // reset right after an m0 grant drops the pending response
      drive(0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
      #1;
      chk("t5_gnt", 32'(m0_gnt), 32'h1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_rvalid_reset", 32'(m0_rvalid), 32'h0);
      chk("t5_cnt_reset", 32'(conflict_cnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drive(1, 1'b1, 1'b0, 1'b0, 32'h0000_0024, 32'h0, 4'hF);
      step();
      chk("t5_m0_wins", 32'(obs_g0), 32'h1);
      idle_both();
      step();

      // randomized traffic; a stalled master keeps its request unchanged
      for (int c = 0; c < 400; c++) begin
         if (!stall0) drive_rand(0);
         if (!stall1) drive_rand(1);
         step();
      end
      idle_both();
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
